// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the read port and write port of a 16-bit word memory (CPU = 0, DMA = 1).
// Define MEM_ARB_AGE_EN to add an aging counter that force-grants the DMA after MAX_WAIT blocked cycles.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [15:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    output logic        mem_wen,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_wdata,
    output logic        busy
);

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } access_t;

    access_t win;
    logic    force1;
    logic    rd0;
    logic    rd1;

`ifdef MEM_ARB_AGE_EN
    localparam logic [3:0] AGE_LIMIT = 4'(MAX_WAIT);

    logic [3:0] age;

    assign force1 = req1 && (age == AGE_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (!req1 || gnt1) begin
            age <= '0;
        end else if (age != AGE_LIMIT) begin
            age <= age + 4'd1;
        end
    end
`else
    logic unused_max_wait;

    assign force1          = 1'b0;
    assign unused_max_wait = ^MAX_WAIT;
`endif

    // Grants are gated by rst_n so nothing reaches the memory while reset is held.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; otherwise a path that skips an assignment infers a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (force1) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = req0;
                gnt1 = req1 && !req0;
            end
        end
    end

    always_comb begin
        win = '0;
        if (gnt0) begin
            win = '{we: we0, addr: addr0, wdata: wdata0};
        end else if (gnt1) begin
            win = '{we: we1, addr: addr1, wdata: wdata1};
        end
    end

    // With no grant win is all zero, so every memory-side output idles at 0.
    assign mem_raddr = win.addr;
    assign mem_wen   = win.we;
    assign mem_waddr = win.we ? win.addr  : 16'h0000;
    assign mem_wdata = win.we ? win.wdata : 16'h0000;

    assign rd0 = gnt0 && !we0;
    assign rd1 = gnt1 && !we1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            busy    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the grants and read data.
            rvalid0 <= rd0;
            rvalid1 <= rd1;
            busy    <= gnt0 || gnt1;
            if (rd0) begin
                rdata0 <= mem_rdata;
            end
            if (rd1) begin
                rdata1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural memory plus read-data scoreboard queues.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_WAIT = 4;
`ifdef MEM_ARB_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_wen, busy;
    logic [15:0] rdata0, rdata1, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

    logic [15:0] mem [0:65535];
    logic        pre_en;
    logic [15:0] pre_addr, pre_data;

    logic [15:0] exp0_q[$];
    logic [15:0] exp1_q[$];
    int          checks;
    int          errors;

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single writer for the memory model: bench preload port or the arbiter's write port.
    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_wen) mem[mem_waddr] <= mem_wdata;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Falling-edge sample; any read response is popped from the scoreboard here.
    task automatic neg();
        logic [15:0] e;
        @(negedge clk);
        if (rvalid0) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid0_unexpected: rvalid0=1 rdata0=%h, no read pending", rdata0);
            end else begin
                e = exp0_q.pop_front();
                if (rdata0 !== e) begin
                    errors++;
                    $display("FAIL rdata0: got %h expected %h", rdata0, e);
                end
            end
        end
        if (rvalid1) begin
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid1_unexpected: rvalid1=1 rdata1=%h, no read pending", rdata1);
            end else begin
                e = exp1_q.pop_front();
                if (rdata1 !== e) begin
                    errors++;
                    $display("FAIL rdata1: got %h expected %h", rdata1, e);
                end
            end
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        cycle();
        pre_en = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: pending reads q0=%0d q1=%0d expected 0/0", name, exp0_q.size(), exp1_q.size());
            exp0_q.delete();
            exp1_q.delete();
        end
    endtask

    task automatic test_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'h5A5A;
        neg();
        checks++;
        if ({gnt0, gnt1, mem_wen, rvalid0, rvalid1, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt0/gnt1/wen/rv0/rv1/busy=%b expected 000000",
                     {gnt0, gnt1, mem_wen, rvalid0, rvalid1, busy});
        end
        checks++;
        if ({rdata0, rdata1, mem_raddr, mem_waddr, mem_wdata} !== 80'h0) begin
            errors++;
            $display("FAIL reset_data: rd0=%h rd1=%h raddr=%h waddr=%h wdata=%h expected all 0",
                     rdata0, rdata1, mem_raddr, mem_waddr, mem_wdata);
        end
        cycle();
        checks++;
        if (mem[16'h0020] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_no_write: mem[0020]=%h expected 0000", mem[16'h0020]);
        end
        neg();
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || mem_wen !== 1'b1 || mem_waddr !== 16'h0020 || mem_wdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL release_grant: gnt0=%b wen=%b waddr=%h wdata=%h expected 1 1 0020 5a5a",
                     gnt0, mem_wen, mem_waddr, mem_wdata);
        end
        cycle();
        req0 = 1'b0; we0 = 1'b0;
        checks++;
        if (mem[16'h0020] !== 16'h5A5A) begin
            errors++;
            $display("FAIL release_write: mem[0020]=%h expected 5a5a", mem[16'h0020]);
        end
        neg();
        checks++;
        if (busy !== 1'b1 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL write_flags: busy=%b rvalid0=%b expected 1 0", busy, rvalid0);
        end
        cycle();
    endtask

    task automatic test_single_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
        neg();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_raddr !== 16'h0010) begin
            errors++;
            $display("FAIL single_grant: gnt1=%b gnt0=%b raddr=%h expected 1 0 0010", gnt1, gnt0, mem_raddr);
        end
        exp1_q.push_back(16'hBEEF);
        cycle();
        req1 = 1'b0;
        neg();
        checks++;
        if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL single_rvalid: rvalid1=%b rvalid0=%b expected 1 0", rvalid1, rvalid0);
        end
        checks++;
        if (gnt1 !== 1'b0 || mem_raddr !== 16'h0000) begin
            errors++;
            $display("FAIL idle_outputs: gnt1=%b raddr=%h expected 0 0000", gnt1, mem_raddr);
        end
        cycle();
        neg();
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_hold: rvalid1=%b rdata1=%h expected 0 beef", rvalid1, rdata1);
        end
        cycle();
        check_drained("single_read");
    endtask

    task automatic test_contention();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        neg();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_raddr !== 16'h0001) begin
            errors++;
            $display("FAIL contend_cpu: gnt0=%b gnt1=%b raddr=%h expected 1 0 0001", gnt0, gnt1, mem_raddr);
        end
        exp0_q.push_back(16'h1111);
        cycle();
        req0 = 1'b0;
        neg();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_raddr !== 16'h0002) begin
            errors++;
            $display("FAIL contend_dma: gnt1=%b gnt0=%b raddr=%h expected 1 0 0002", gnt1, gnt0, mem_raddr);
        end
        exp1_q.push_back(16'h2222);
        cycle();
        req1 = 1'b0;
        neg();
        cycle();
        check_drained("contention");
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; we0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr0 = 16'h0030 + 16'(i);
            neg();
            checks++;
            if (gnt0 !== 1'b1 || (i > 0 && busy !== 1'b1)) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: gnt0=%b busy=%b expected 1 1", i, gnt0, busy);
            end
            exp0_q.push_back(16'hC000 + 16'(i));
            cycle();
        end
        req0 = 1'b0;
        neg();
        cycle();
        check_drained("back_to_back");
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0100; wdata0 = 16'h1234;
        neg();
        checks++;
        if (mem_wen !== 1'b1 || mem_waddr !== 16'h0100 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL wr_port: wen=%b waddr=%h wdata=%h expected 1 0100 1234", mem_wen, mem_waddr, mem_wdata);
        end
        cycle();
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0100;
        neg();
        checks++;
        if (gnt1 !== 1'b1 || rvalid0 !== 1'b0 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL wr_then_rd: gnt1=%b rvalid0=%b wen=%b expected 1 0 0", gnt1, rvalid0, mem_wen);
        end
        exp1_q.push_back(16'h1234);
        cycle();
        req1 = 1'b0;
        neg();
        cycle();
        check_drained("write_read");
    endtask

    task automatic test_aging();
        bit exp_g1;
        bit seen_g1;
        seen_g1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0041;
        for (int i = 1; i <= 8; i++) begin
            exp_g1 = AGE_EN && !seen_g1 && (i == int'(MAX_WAIT) + 1);
            neg();
            checks++;
            if (gnt1 !== exp_g1 || gnt0 !== !exp_g1) begin
                errors++;
                $display("FAIL aging[%0d]: gnt0=%b gnt1=%b expected %b %b", i, gnt0, gnt1, !exp_g1, exp_g1);
            end
            if (exp_g1) exp1_q.push_back(16'h4141);
            else        exp0_q.push_back(16'h4040);
            cycle();
            if (exp_g1) begin
                seen_g1 = 1'b1;
                req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        neg();
        cycle();
        check_drained("aging");
    endtask

    task automatic test_mid_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'hAAAA;
        neg();
        checks++;
        if (gnt0 !== 1'b1 || mem_wen !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: gnt0=%b wen=%b expected 1 1", gnt0, mem_wen);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_gate: gnt0=%b wen=%b expected 0 0", gnt0, mem_wen);
        end
        cycle();
        checks++;
        if (mem[16'h0005] !== 16'h1357) begin
            errors++;
            $display("FAIL midrst_mem: mem[0005]=%h expected 1357", mem[16'h0005]);
        end
        checks++;
        if ({rvalid0, rvalid1, busy} !== 3'b000 || rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_regs: rv0/rv1/busy=%b rd0=%h rd1=%h expected 000 0000 0000",
                     {rvalid0, rvalid1, busy}, rdata0, rdata1);
        end
        req0 = 1'b0; we0 = 1'b0;
        neg();
        rst_n = 1'b1;
        cycle();
        check_drained("mid_reset");
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        preload(16'h0020, 16'h0000);
        preload(16'h0010, 16'hBEEF);
        preload(16'h0001, 16'h1111);
        preload(16'h0002, 16'h2222);
        preload(16'h0005, 16'h1357);
        preload(16'h0040, 16'h4040);
        preload(16'h0041, 16'h4141);
        for (int i = 0; i < 4; i++) preload(16'h0030 + 16'(i), 16'hC000 + 16'(i));
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_write_read();
        test_aging();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
